// File: rtl/nrzi_pkg.sv
// -----------------------------------------------------------------------------
// nrzi_pkg
// Shared definitions for the NRZI line path.
// The receive deserializer and the line encoder both use this package.
//   rx_state_t       : bit-stuffing state of the receiver
//   NRZI_STUFF_LEN   : decoded 1s after which one stuffed 0 follows
//   NRZI_IDLE_LEVEL  : line level at reset and at frame restart
//   nrzi_decode()    : one NRZI sample -> data bit (level held = 1)
// -----------------------------------------------------------------------------
package nrzi_pkg;

    typedef enum logic [0:0] {
        ST_DATA  = 1'b0,
        ST_STUFF = 1'b1
    } rx_state_t;

    localparam int   NRZI_STUFF_LEN  = 6;
    localparam logic NRZI_IDLE_LEVEL = 1'b1;

    // A held level carries a 1 and a toggled level carries a 0.
    function automatic logic nrzi_decode(input logic level, input logic prev_level);
        return (level == prev_level);
    endfunction

endpackage

// File: rtl/nrzi_bit_decoder.sv
// -----------------------------------------------------------------------------
// nrzi_bit_decoder
// Stores the previous line level and turns each line sample into a data bit.
//   clk          in  rising-edge clock
//   areset_n     in  asynchronous active-low reset
//   i_line_in    in  sampled NRZI line level
//   i_line_valid in  i_line_in holds a new sample this cycle
//   i_sync_clr   in  frame restart; forces the level back to IDLE_LEVEL
//   o_bit        out decoded bit (combinational)
//   o_bit_valid  out o_bit is meaningful this cycle (combinational)
// -----------------------------------------------------------------------------
module nrzi_bit_decoder
    import nrzi_pkg::*;
#(
    parameter logic IDLE_LEVEL = NRZI_IDLE_LEVEL
) (
    input  logic clk,
    input  logic areset_n,
    input  logic i_line_in,
    input  logic i_line_valid,
    input  logic i_sync_clr,
    output logic o_bit,
    output logic o_bit_valid
);

    logic r_prev_level;

    // Previous-level register; a frame restart takes priority over a sample.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_prev_level <= IDLE_LEVEL;
        end else if (i_sync_clr) begin
            r_prev_level <= IDLE_LEVEL;
        end else if (i_line_valid) begin
            r_prev_level <= i_line_in;
        end else begin
            r_prev_level <= r_prev_level;
        end
    end

    // A sample that arrives together with sync_clr is not decoded.
    assign o_bit       = nrzi_decode(i_line_in, r_prev_level);
    assign o_bit_valid = i_line_valid & ~i_sync_clr;

endmodule

// File: rtl/nrzi_rx_deserializer.sv
// -----------------------------------------------------------------------------
// nrzi_rx_deserializer
// Decodes an NRZI line, removes stuffed zeros and assembles LSB-first words.
// The words are presented on a valid/ready interface.
//   clk        in  rising-edge clock
//   areset_n   in  asynchronous active-low reset
//   line_in    in  sampled NRZI line level
//   line_valid in  line_in holds a new sample this cycle
//   sync_clr   in  synchronous frame restart (output register untouched)
//   data_out   out assembled word, LSB received first
//   data_valid out data_out holds an unconsumed word
//   data_ready in  downstream accepts the word this cycle
//   stuff_err  out one-cycle pulse: a 1 arrived where a stuffed 0 was due
//   overrun    out one-cycle pulse: a word was dropped because the output was full
// -----------------------------------------------------------------------------
module nrzi_rx_deserializer
    import nrzi_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   STUFF_LEN  = NRZI_STUFF_LEN,
    parameter logic IDLE_LEVEL = NRZI_IDLE_LEVEL
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              line_in,
    input  logic              line_valid,
    input  logic              sync_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              stuff_err,
    output logic              overrun
);

    localparam int CNT_W  = $clog2(DATA_W);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [ONES_W-1:0] STUFF_ONES = ONES_W'(STUFF_LEN);

    rx_state_t         r_state;
    logic [ONES_W-1:0] r_ones_cnt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_stuff_err;
    logic              r_overrun;

    logic              w_bit;
    logic              w_bit_valid;
    logic [DATA_W-1:0] w_word;
    logic [ONES_W-1:0] w_ones_inc;
    logic              w_word_done;
    logic              w_stuff_viol;

    nrzi_bit_decoder #(
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_bit_decoder (
        .clk          (clk),
        .areset_n     (areset_n),
        .i_line_in    (line_in),
        .i_line_valid (line_valid),
        .i_sync_clr   (sync_clr),
        .o_bit        (w_bit),
        .o_bit_valid  (w_bit_valid)
    );

    assign w_word     = {w_bit, r_shreg[DATA_W-1:1]};
    assign w_ones_inc = r_ones_cnt + ONES_W'(1);

    // Classifies the current decoded bit as word completion or stuff violation.
    always_comb begin
        w_word_done  = 1'b0;
        w_stuff_viol = 1'b0;
        if (w_bit_valid) begin
            case (r_state)
                ST_DATA:  w_word_done  = (r_bit_cnt == LAST_BIT);
                ST_STUFF: w_stuff_viol = w_bit;
                default: begin
                    w_word_done  = 1'b0;
                    w_stuff_viol = 1'b0;
                end
            endcase
        end else begin
            w_word_done  = 1'b0;
            w_stuff_viol = 1'b0;
        end
    end

    // Stuff FSM, shift register and counters.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state    <= ST_DATA;
            r_ones_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
        end else if (sync_clr) begin
            r_state    <= ST_DATA;
            r_ones_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
        end else if (w_bit_valid) begin
            case (r_state)
                ST_DATA: begin
                    r_shreg   <= w_word;
                    r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
                    // The run of ones carries across word boundaries.
                    if (w_bit) begin
                        if (w_ones_inc == STUFF_ONES) begin
                            r_state    <= ST_STUFF;
                            r_ones_cnt <= '0;
                        end else begin
                            r_ones_cnt <= w_ones_inc;
                        end
                    end else begin
                        r_ones_cnt <= '0;
                    end
                end
                ST_STUFF: begin
                    r_state <= ST_DATA;
                    // A 1 in the stuff slot drops the partial word.
                    if (w_bit) begin
                        r_ones_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_shreg    <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_DATA;
                    r_ones_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_shreg    <= '0;
                end
            endcase
        end
    end

    // Output register, valid/ready handshake and the error pulses.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_stuff_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_stuff_err <= w_stuff_viol;
            r_overrun   <= 1'b0;
            if (w_word_done) begin
                // The slot is free when empty or being drained this cycle.
                if (!r_data_valid || data_ready) begin
                    r_data_out   <= w_word;
                    r_data_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (data_ready) begin
                r_data_valid <= 1'b0;
            end else begin
                r_data_valid <= r_data_valid;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign stuff_err  = r_stuff_err;
    assign overrun    = r_overrun;

endmodule
